// File: rtl/debounce_pkg.sv
// Shared types and defaults for the shared-timer button debouncer.
package debounce_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TIMING = 2'd1,
        ST_COMMIT = 2'd2
    } dbs_state_e;

    localparam int DEF_TIMER_CYCLES = 2_000_000;
    localparam int DEF_CNT_W        = 21;

endpackage

// File: rtl/debounce_rr_arbiter.sv
// Combinational round-robin picker: first pending channel at or after
// the pointer, wrapping.
module debounce_rr_arbiter
    import debounce_pkg::*;
#(
    parameter int N_BTN = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_BTN-1:0] i_pending,
    input  logic [IDX_W-1:0] i_rr_ptr,
    output logic             o_grant_valid,
    output logic [IDX_W-1:0] o_grant_idx
);

    int w_idx;

    // Scan from the farthest offset down so the nearest pending one wins.
    always_comb begin
        o_grant_valid = 1'b0;
        o_grant_idx   = '0;
        w_idx         = 0;
        for (int k = N_BTN - 1; k >= 0; k--) begin
            w_idx = (int'(i_rr_ptr) + k) % N_BTN;
            if (i_pending[w_idx]) begin
                o_grant_valid = 1'b1;
                o_grant_idx   = IDX_W'(w_idx);
            end
        end
    end

endmodule

// File: rtl/debounce_scheduler.sv
// Debounces N_BTN buttons with one shared interval counter, handed out
// round-robin to channels whose synchronized input differs from the committed level.
module debounce_scheduler
    import debounce_pkg::*;
#(
    parameter  int N_BTN        = 4,
    parameter  int TIMER_CYCLES = DEF_TIMER_CYCLES,
    parameter  int CNT_W        = DEF_CNT_W,
    localparam int IDX_W        = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] button,
    output logic [N_BTN-1:0] debounced,
    output logic [N_BTN-1:0] pulse,
    output logic             busy,
    output logic [IDX_W-1:0] active_ch
);

    logic [N_BTN-1:0] r_sync1;
    logic [N_BTN-1:0] r_sync2;
    logic [N_BTN-1:0] r_deb;
    logic [N_BTN-1:0] r_pulse;
    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] r_cur;
    dbs_state_e       r_state;
    dbs_state_e       w_state_nxt;

    logic [N_BTN-1:0] w_pending;
    logic             w_grant_valid;
    logic [IDX_W-1:0] w_grant_idx;
    logic             w_s_cur;
    logic             w_d_cur;
    logic             w_last;
    logic             w_bounce;
    logic [IDX_W-1:0] w_ptr_inc;

    assign w_pending = r_sync2 ^ r_deb;
    assign w_s_cur   = r_sync2[r_cur];
    assign w_d_cur   = r_deb[r_cur];
    assign w_bounce  = (w_s_cur == w_d_cur);
    assign w_last    = (r_cnt == CNT_W'(TIMER_CYCLES - 1));
    assign w_ptr_inc = (r_cur == IDX_W'(N_BTN - 1)) ? '0 : r_cur + IDX_W'(1);

    debounce_rr_arbiter #(
        .N_BTN (N_BTN),
        .IDX_W (IDX_W)
    ) u_arb (
        .i_pending     (w_pending),
        .i_rr_ptr      (r_ptr),
        .o_grant_valid (w_grant_valid),
        .o_grant_idx   (w_grant_idx)
    );

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_grant_valid) w_state_nxt = ST_TIMING;
            end
            ST_TIMING: begin
                // A bounce back on the final count still aborts.
                if (w_bounce)    w_state_nxt = ST_IDLE;
                else if (w_last) w_state_nxt = ST_COMMIT;
            end
            ST_COMMIT: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_deb   <= '0;
            r_pulse <= '0;
            r_cnt   <= '0;
            r_ptr   <= '0;
            r_cur   <= '0;
            r_state <= ST_IDLE;
        end else begin
            r_sync1 <= button;
            r_sync2 <= r_sync1;
            r_state <= w_state_nxt;
            r_pulse <= '0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_grant_valid) begin
                        r_cur <= w_grant_idx;
                        r_cnt <= '0;
                    end
                end
                ST_TIMING: begin
                    if (w_bounce)     r_ptr <= w_ptr_inc;
                    else if (!w_last) r_cnt <= r_cnt + CNT_W'(1);
                end
                ST_COMMIT: begin
                    r_deb[r_cur]   <= w_s_cur;
                    r_pulse[r_cur] <= w_s_cur & ~w_d_cur;
                    r_ptr          <= w_ptr_inc;
                end
                default: ;
            endcase
        end
    end

    assign debounced = r_deb;
    assign pulse     = r_pulse;
    assign busy      = (r_state != ST_IDLE);
    assign active_ch = r_cur;

endmodule

// File: tb/tb_debounce_scheduler.sv
// Bench for debounce_scheduler: directed latency scenarios plus random
// bouncing inputs against a grant-timeline reference model.
module tb_debounce_scheduler;

    localparam int N  = 4;
    localparam int TC = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] btn;
    logic [N-1:0] dbn;
    logic [N-1:0] pls;
    logic         busy;
    logic [1:0]   ach;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference: owner channel and the cycle it was granted; phase since
    // grant decides timing window vs commit.
    int           cyc     = 0;
    int           m_owner = -1;
    int           m_gstart = 0;
    int           m_ptr   = 0;
    logic [N-1:0] m_s1    = '0;
    logic [N-1:0] m_s2    = '0;
    logic [N-1:0] m_deb   = '0;
    logic [N-1:0] m_pul   = '0;

    debounce_scheduler #(
        .N_BTN        (N),
        .TIMER_CYCLES (TC),
        .CNT_W        (4)
    ) dut (
        .clk       (clk),
        .reset     (rst),
        .button    (btn),
        .debounced (dbn),
        .pulse     (pls),
        .busy      (busy),
        .active_ch (ach)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h",
                     tag, cyc, got, exp);
        end
    endtask

    task automatic model_edge();
        logic [N-1:0] deb_n;
        logic [N-1:0] pul_n;
        int           own_n;
        int           ptr_n;
        int           ph;
        cyc++;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_deb = '0; m_pul = '0;
            m_owner = -1; m_ptr = 0;
            return;
        end
        deb_n = m_deb;
        pul_n = '0;
        own_n = m_owner;
        ptr_n = m_ptr;
        if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                int idx = (m_ptr + k) % N;
                if (own_n < 0 && m_s2[idx] != m_deb[idx]) begin
                    own_n    = idx;
                    m_gstart = cyc;
                end
            end
        end else begin
            ph = cyc - m_gstart;
            if (ph <= TC) begin
                if (m_s2[m_owner] == m_deb[m_owner]) begin
                    own_n = -1;
                    ptr_n = (m_owner + 1) % N;
                end
            end else begin
                deb_n[m_owner] = m_s2[m_owner];
                pul_n[m_owner] = m_s2[m_owner] & ~m_deb[m_owner];
                own_n = -1;
                ptr_n = (m_owner + 1) % N;
            end
        end
        m_deb   = deb_n;
        m_pul   = pul_n;
        m_owner = own_n;
        m_ptr   = ptr_n;
        m_s2    = m_s1;
        m_s1    = btn;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("debounced", 32'(dbn), 32'(m_deb));
        chk("pulse", 32'(pls), 32'(m_pul));
        chk("busy", 32'(busy), 32'(m_owner >= 0));
        if (m_owner >= 0) chk("active_ch", 32'(ach), 32'(m_owner));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    logic [N-1:0] exp_d;
    logic [N-1:0] exp_p;

    initial begin
        rst = 1'b1;
        btn = '0;
        run(2);
        rst = 1'b0;
        run(3);

        // All four at once: commits in order 0..3, spaced TC+2.
        btn = 4'hF;
        for (int k = 1; k <= 42; k++) begin
            tick();
            if (k == 11) chk("all_pre", 32'(dbn), 32'h0);
            if (k >= 12 && (k - 12) % 10 == 0) begin
                exp_d = 4'((1 << ((k - 12) / 10 + 1)) - 1);
                exp_p = 4'(1 << ((k - 12) / 10));
                chk("all_deb", 32'(dbn), 32'(exp_d));
                chk("all_pulse", 32'(pls), 32'(exp_p));
            end
        end
        btn = '0;
        run(45);
        chk("all_release", 32'(dbn), 32'h0);

        // Clean press on ch0.
        btn = 4'b0001;
        for (int k = 1; k <= 13; k++) begin
            tick();
            if (k == 11) chk("press_early", 32'(dbn[0]), 32'h0);
            if (k == 12) begin
                chk("press_deb", 32'(dbn[0]), 32'h1);
                chk("press_pulse", 32'(pls[0]), 32'h1);
            end
            if (k == 13) chk("press_pulse_end", 32'(pls[0]), 32'h0);
        end
        run(5);

        // Release on ch0: no pulse.
        btn = 4'b0000;
        for (int k = 1; k <= 13; k++) begin
            tick();
            if (k == 11) chk("rel_early", 32'(dbn[0]), 32'h1);
            if (k == 12) begin
                chk("rel_deb", 32'(dbn[0]), 32'h0);
                chk("rel_pulse", 32'(pls), 32'h0);
            end
        end
        run(5);

        // Short glitch on ch1: granted, then aborted.
        btn = 4'b0010;
        for (int k = 1; k <= 25; k++) begin
            if (k == 6) btn = 4'b0000;
            tick();
            if (k == 3) chk("glitch_busy", 32'(busy), 32'h1);
            if (k == 8) chk("glitch_abort", 32'(busy), 32'h0);
            chk("glitch_pulse", 32'(pls[1]), 32'h0);
        end
        chk("glitch_deb", 32'(dbn[1]), 32'h0);

        // Reset while ch2 is mid-interval, then re-time from scratch.
        btn = 4'b0100;
        run(7);
        chk("rst_mid_busy", 32'(busy), 32'h1);
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("rst_deb", 32'(dbn), 32'h0);
            chk("rst_pulse", 32'(pls), 32'h0);
            chk("rst_busy", 32'(busy), 32'h0);
        end
        rst = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 11) chk("rst_retime_early", 32'(dbn[2]), 32'h0);
            if (k == 12) chk("rst_retime_deb", 32'(dbn[2]), 32'h1);
        end
        btn = '0;
        run(15);

        // Random bouncing with occasional resets.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                int b = int'($urandom_range(0, N - 1));
                btn[b] = ~btn[b];
            end
            rst = ($urandom_range(0, 799) == 0);
            tick();
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
